fsk_hdlc_txsched: RTL and testbench

Half-duplex channel scheduler for the FSK modem HDLC transceiver. It owns PTT and RX enable, and defers to carrier detect before keying up. It sequences the HDLC framer through preamble flags, payload bytes, CRC, and tail flags. It also enforces underrun abort and a keyed-time watchdog. It sits between the host byte interface and the framer/bit-stuffer, and is clocked by the design clock with a baud strobe from the modem.

---
 rtl/fsk_hdlc_txsched.sv | 250 +++++++++++++++++++++++++
 tb/tb_fsk_hdlc_txsched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_hdlc_txsched.sv
`default_nettype none
// ============================================================================
// Module   : fsk_hdlc_txsched
// Purpose  : Half-duplex transmit scheduler for the FSK HDLC modem. Defers to
//            carrier, keys PTT, walks the framer through preamble flags,
//            payload, CRC and tail flags, and aborts on host underrun or on
//            keyed-time watchdog expiry.
// Revision : 1.0 - initial release
// ============================================================================
module fsk_hdlc_txsched #(
   parameter logic [3:0]  PREAMBLE_FLAGS = 4'd4,
   parameter logic [3:0]  TAIL_FLAGS     = 4'd2,
   parameter logic [7:0]  TXDELAY_TICKS  = 8'd16,
   parameter logic [7:0]  HOLDOFF_TICKS  = 8'd8,
   parameter logic [15:0] WDOG_TICKS     = 16'd4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_tick,
   input  logic       dcd,
   input  logic       tx_req,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       fr_cmd_valid,
   output logic [1:0] fr_cmd,
   output logic [7:0] fr_data,
   input  logic       fr_ready,
   input  logic       fr_empty,
   output logic       ptt,
   output logic       rx_en,
   output logic       tx_done,
   output logic       err_underrun,
   output logic       err_wdog,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DEFER    = 3'd1,
      S_KEYUP    = 3'd2,
      S_PREAMBLE = 3'd3,
      S_DATA     = 3'd4,
      S_CRC      = 3'd5,
      S_TAIL     = 3'd6,
      S_DRAIN    = 3'd7
   } state_e;

   localparam logic [1:0] CMD_FLAG  = 2'd0;
   localparam logic [1:0] CMD_DATA  = 2'd1;
   localparam logic [1:0] CMD_CRC   = 2'd2;
   localparam logic [1:0] CMD_ABORT = 2'd3;

   state_e      state_q, state_d;
   logic [7:0]  hold_q, hold_d;
   logic [7:0]  delay_q, delay_d;
   logic [3:0]  flag_q, flag_d;
   logic [15:0] wdog_q;
   logic        abort_q, abort_d;       // ABORT offer pending
   logic        abort_wd_q, abort_wd_d; // pending ABORT was caused by the watchdog
   logic        aborted_q, aborted_d;   // this frame ended in an abort

   logic        keyed;
   logic        active;
   logic        next_active;
   logic        wdog_fire;
   logic        underrun;

   // PTT covers every state from key-up until the drain completes
   assign keyed  = (state_q != S_IDLE) && (state_q != S_DEFER);
   // States in which the watchdog may still cut the frame short
   assign active = keyed && (state_q != S_TAIL) && (state_q != S_DRAIN);
   assign ptt    = keyed;
   assign rx_en  = ~keyed;
   assign state  = state_q;

   // State and per-frame counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         hold_q     <= 8'd0;
         delay_q    <= 8'd0;
         flag_q     <= 4'd0;
         abort_q    <= 1'b0;
         abort_wd_q <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         delay_q    <= delay_d;
         flag_q     <= flag_d;
         abort_q    <= abort_d;
         abort_wd_q <= abort_wd_d;
         aborted_q  <= aborted_d;
      end
   end

   // Keyed-time watchdog: counts baud ticks while keyed and saturates at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= 16'd0;
      end else if (!keyed) begin
         wdog_q <= 16'd0;
      end else if (bit_tick && (wdog_q != WDOG_TICKS)) begin
         wdog_q <= wdog_q + 16'd1;
      end
   end

   // Framer command offer and host handshake; a pending ABORT overrides everything
   always_comb begin
      fr_cmd_valid = 1'b0;
      fr_cmd       = CMD_FLAG;
      fr_data      = 8'h00;
      tx_ready     = 1'b0;
      if (abort_q) begin
         fr_cmd_valid = 1'b1;
         fr_cmd       = CMD_ABORT;
      end else begin
         case (state_q)
            S_PREAMBLE, S_TAIL: begin
               fr_cmd_valid = 1'b1;
               fr_cmd       = CMD_FLAG;
            end
            S_DATA: begin
               fr_cmd_valid = tx_valid;
               fr_cmd       = CMD_DATA;
               fr_data      = tx_valid ? tx_data : 8'h00;
               tx_ready     = fr_ready;
            end
            S_CRC: begin
               fr_cmd_valid = 1'b1;
               fr_cmd       = CMD_CRC;
            end
            default: ;
         endcase
      end
   end

   // Next-state, counter updates, abort arming and status pulses
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      delay_d      = delay_q;
      flag_d       = flag_q;
      abort_d      = abort_q;
      abort_wd_d   = abort_wd_q;
      aborted_d    = aborted_q;
      tx_done      = 1'b0;
      err_underrun = 1'b0;
      err_wdog     = 1'b0;
      next_active  = 1'b0;
      wdog_fire    = 1'b0;
      underrun     = 1'b0;

      if (abort_q) begin
         if (fr_ready) begin
            state_d      = S_TAIL;
            flag_d       = 4'd0;
            abort_d      = 1'b0;
            aborted_d    = 1'b1;
            err_wdog     = abort_wd_q;
            err_underrun = ~abort_wd_q;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tx_req) begin
                  state_d   = S_DEFER;
                  hold_d    = 8'd0;
                  aborted_d = 1'b0;
               end
            end
            S_DEFER: begin
               // Carrier clears the holdoff even on a coincident baud tick
               if (!tx_req) begin
                  state_d = S_IDLE;
               end else if (dcd) begin
                  hold_d = 8'd0;
               end else if (bit_tick) begin
                  hold_d = hold_q + 8'd1;
                  if (hold_q + 8'd1 == HOLDOFF_TICKS) begin
                     state_d = S_KEYUP;
                     delay_d = 8'd0;
                  end
               end
            end
            S_KEYUP: begin
               if (bit_tick) begin
                  delay_d = delay_q + 8'd1;
                  if (delay_q + 8'd1 == TXDELAY_TICKS) begin
                     state_d = S_PREAMBLE;
                     flag_d  = 4'd0;
                  end
               end
            end
            S_PREAMBLE: begin
               if (fr_ready) begin
                  flag_d = flag_q + 4'd1;
                  if (flag_q + 4'd1 == PREAMBLE_FLAGS) begin
                     state_d = S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (tx_valid && fr_ready && tx_last) begin
                  state_d = S_CRC;
               end
            end
            S_CRC: begin
               if (fr_ready) begin
                  state_d = S_TAIL;
                  flag_d  = 4'd0;
               end
            end
            S_TAIL: begin
               if (fr_ready) begin
                  flag_d = flag_q + 4'd1;
                  if (flag_q + 4'd1 == TAIL_FLAGS) begin
                     state_d = S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (fr_empty) begin
                  state_d = S_IDLE;
                  tx_done = ~aborted_q;
               end
            end
            default: state_d = S_IDLE;
         endcase

         // An abort is only armed if this cycle does not already move the
         // frame into its tail; the current offer still completes this cycle
         next_active = (state_d == S_KEYUP) || (state_d == S_PREAMBLE) ||
                       (state_d == S_DATA)  || (state_d == S_CRC);
         wdog_fire   = active && next_active && (wdog_q == WDOG_TICKS);
         underrun    = (state_q == S_DATA) && fr_empty && !tx_valid;
         if (wdog_fire) begin
            abort_d    = 1'b1;
            abort_wd_d = 1'b1;
         end else if (underrun) begin
            abort_d    = 1'b1;
            abort_wd_d = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fsk_hdlc_txsched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsk_hdlc_txsched
// Purpose  : Directed self-checking bench for fsk_hdlc_txsched with a framer
//            command scoreboard and a simple host byte source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsk_hdlc_txsched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bit_tick;
   logic       dcd;
   logic       tx_req;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_ready;
   logic       fr_cmd_valid;
   logic [1:0] fr_cmd;
   logic [7:0] fr_data;
   logic       fr_ready;
   logic       fr_empty;
   logic       ptt;
   logic       rx_en;
   logic       tx_done;
   logic       err_underrun;
   logic       err_wdog;
   logic [2:0] state;

   fsk_hdlc_txsched #(
      .PREAMBLE_FLAGS (4'd4),
      .TAIL_FLAGS     (4'd2),
      .TXDELAY_TICKS  (8'd16),
      .HOLDOFF_TICKS  (8'd8),
      .WDOG_TICKS     (16'd40)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bit_tick     (bit_tick),
      .dcd          (dcd),
      .tx_req       (tx_req),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_last      (tx_last),
      .tx_ready     (tx_ready),
      .fr_cmd_valid (fr_cmd_valid),
      .fr_cmd       (fr_cmd),
      .fr_data      (fr_data),
      .fr_ready     (fr_ready),
      .fr_empty     (fr_empty),
      .ptt          (ptt),
      .rx_en        (rx_en),
      .tx_done      (tx_done),
      .err_underrun (err_underrun),
      .err_wdog     (err_wdog),
      .state        (state)
   );

   always #5 clk = ~clk;

   // Scoreboard of expected framer commands {cmd, data}, host byte source {last, data}
   logic [9:0] exp_q[$];
   logic [8:0] host_q[$];

   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;
   bit   bp_mode = 1'b0;
   bit   host_en = 1'b0;
   bit   prev_stall = 1'b0;
   logic [9:0] prev_offer = 10'd0;
   bit   prev_ptt = 1'b0;
   bit   prev_req = 1'b0;
   int   since_dcd = 0;
   int   ptt_ticks = 0;
   int   rise_since = -1;
   int   first_flag_ticks = -1;
   int   abort_ticks = -1;
   bit   seen_flag = 1'b0;
   bit   seen_abort = 1'b0;
   int   n_done = 0;
   int   n_unr = 0;
   int   n_wd = 0;

   task automatic chk(input string tag, input int got, input int exp);
      vec_cnt++;
      assert (got === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expire(input string tag, input bit reached);
      vec_cnt++;
      assert (reached) else begin
         err_cnt++;
         $error("FAIL %s: observed timeout expected event within budget", tag);
      end
   endtask

   task automatic push_cmd(input logic [1:0] c, input logic [7:0] d);
      exp_q.push_back({c, d});
   endtask

   task automatic push_flags(input int n);
      for (int i = 0; i < n; i++) push_cmd(2'd0, 8'h00);
   endtask

   task automatic clr_stats();
      n_done = 0; n_unr = 0; n_wd = 0;
      seen_flag = 1'b0; seen_abort = 1'b0;
      rise_since = -1; first_flag_ticks = -1; abort_ticks = -1;
   endtask

   // One clock period: drive at the negedge, settle, observe, then advance
   task automatic cycle();
      logic [9:0] e;
      bit_tick = (cyc % 4 == 3);
      if (bp_mode) fr_ready = (cyc % 2 == 0);
      tx_valid = host_en && (host_q.size() > 0);
      tx_data  = tx_valid ? host_q[0][7:0] : 8'h00;
      tx_last  = tx_valid ? host_q[0][8] : 1'b0;
      #1;
      if (bp_mode && prev_stall) begin
         chk("hold_valid", 32'(fr_cmd_valid), 1);
         chk("hold_offer", 32'({fr_cmd, fr_data}), 32'(prev_offer));
      end
      if (fr_cmd_valid && ptt && !seen_flag) begin
         seen_flag = 1'b1;
         first_flag_ticks = ptt_ticks;
      end
      if (fr_cmd_valid && (fr_cmd == 2'd3) && !seen_abort) begin
         seen_abort = 1'b1;
         abort_ticks = ptt_ticks;
      end
      if (fr_cmd_valid && fr_ready) begin
         vec_cnt++;
         assert (exp_q.size() > 0) else begin
            err_cnt++;
            $error("FAIL unexpected_cmd: observed %0h expected none", {fr_cmd, fr_data});
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fr_cmd", 32'({fr_cmd, fr_data}), 32'(e));
         end
      end
      prev_stall = fr_cmd_valid && !fr_ready;
      prev_offer = {fr_cmd, fr_data};
      if (tx_valid && tx_ready) void'(host_q.pop_front());
      n_done += int'(tx_done);
      n_unr  += int'(err_underrun);
      n_wd   += int'(err_wdog);
      if (ptt && !prev_ptt) begin
         rise_since = since_dcd;
         ptt_ticks  = 0;
      end
      if (ptt && bit_tick) ptt_ticks++;
      if (tx_req && !prev_req) since_dcd = 0;
      else if (dcd) since_dcd = 0;
      else if (bit_tick) since_dcd++;
      prev_req = tx_req;
      prev_ptt = ptt;
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_ptt(input logic v, input int budget, input string tag);
      int n = 0;
      while ((ptt !== v) && (n < budget)) begin cycle(); n++; end
      expire(tag, ptt === v);
   endtask

   task automatic wait_sb(input int depth, input int budget, input string tag);
      int n = 0;
      while ((exp_q.size() > depth) && (n < budget)) begin cycle(); n++; end
      expire(tag, exp_q.size() <= depth);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: observed hang expected completion");
      $fatal(1, "global timeout");
   end

   initial begin
      rst_n = 1'b0; bit_tick = 1'b0; dcd = 1'b0; tx_req = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
      fr_ready = 1'b1; fr_empty = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(state), 0);
      chk("rst_ptt", 32'(ptt), 0);
      chk("rst_rx_en", 32'(rx_en), 1);
      chk("rst_outs", 32'({tx_ready, fr_cmd_valid, fr_cmd, fr_data, tx_done, err_underrun, err_wdog}), 0);
      rst_n = 1'b1;
      cycle();

      // Clean frame: 7E 01 A5
      clr_stats();
      host_q.push_back(9'h07E); host_q.push_back(9'h001); host_q.push_back(9'h1A5);
      push_flags(4); push_cmd(2'd1, 8'h7E); push_cmd(2'd1, 8'h01); push_cmd(2'd1, 8'hA5);
      push_cmd(2'd2, 8'h00); push_flags(2);
      host_en = 1'b1; tx_req = 1'b1;
      wait_ptt(1'b1, 400, "clean_keyup");
      tx_req = 1'b0;
      wait_sb(0, 600, "clean_frame");
      fr_empty = 1'b1;
      wait_ptt(1'b0, 50, "clean_unkey");
      fr_empty = 1'b0;
      chk("clean_holdoff_ticks", rise_since, 8);
      chk("clean_txdelay_ticks", first_flag_ticks, 16);
      chk("clean_tx_done", n_done, 1);
      chk("clean_errs", n_unr + n_wd, 0);
      chk("clean_idle", 32'({state, rx_en}), 32'({3'd0, 1'b1}));
      cycle();

      // Carrier defer with a dcd pulse coincident with a baud tick
      clr_stats();
      host_q.push_back(9'h13C);
      push_flags(4); push_cmd(2'd1, 8'h3C); push_cmd(2'd2, 8'h00); push_flags(2);
      dcd = 1'b1; tx_req = 1'b1;
      repeat (80) cycle();
      chk("defer_ptt_low", 32'(ptt), 0);
      dcd = 1'b0;
      repeat (20) cycle();
      while (cyc % 4 != 3) cycle();
      dcd = 1'b1;
      cycle();
      dcd = 1'b0;
      wait_ptt(1'b1, 200, "defer_keyup");
      tx_req = 1'b0;
      wait_sb(0, 600, "defer_frame");
      fr_empty = 1'b1;
      wait_ptt(1'b0, 50, "defer_unkey");
      fr_empty = 1'b0;
      chk("defer_holdoff_ticks", rise_since, 8);
      chk("defer_tx_done", n_done, 1);
      cycle();

      // Underrun: one byte, no last, framer drains
      clr_stats();
      host_q.push_back(9'h055);
      push_flags(4); push_cmd(2'd1, 8'h55); push_cmd(2'd3, 8'h00); push_flags(2);
      tx_req = 1'b1;
      wait_ptt(1'b1, 400, "unr_keyup");
      tx_req = 1'b0;
      wait_sb(3, 600, "unr_data");
      repeat (3) cycle();
      fr_empty = 1'b1;
      wait_sb(0, 100, "unr_abort_tail");
      wait_ptt(1'b0, 50, "unr_unkey");
      fr_empty = 1'b0;
      chk("unr_err_underrun", n_unr, 1);
      chk("unr_err_wdog", n_wd, 0);
      chk("unr_tx_done", n_done, 0);
      cycle();

      // Watchdog: host keeps a byte pending while the framer stalls
      clr_stats();
      host_q.push_back(9'h011); host_q.push_back(9'h022); host_q.push_back(9'h033);
      push_flags(4); push_cmd(2'd1, 8'h11); push_cmd(2'd1, 8'h22);
      push_cmd(2'd3, 8'h00); push_flags(2);
      tx_req = 1'b1;
      wait_ptt(1'b1, 400, "wd_keyup");
      tx_req = 1'b0;
      wait_sb(3, 600, "wd_data");
      fr_ready = 1'b0;
      begin
         int n = 0;
         while (!seen_abort && (n < 400)) begin cycle(); n++; end
         expire("wd_abort_offer", seen_abort);
      end
      fr_ready = 1'b1;
      host_q.delete();
      wait_sb(0, 100, "wd_abort_tail");
      fr_empty = 1'b1;
      wait_ptt(1'b0, 50, "wd_unkey");
      fr_empty = 1'b0;
      chk("wd_abort_ticks", abort_ticks, 40);
      chk("wd_err_wdog", n_wd, 1);
      chk("wd_err_underrun", n_unr, 0);
      chk("wd_tx_done", n_done, 0);
      chk("wd_ptt_off", 32'(ptt), 0);
      cycle();

      // Backpressure: framer ready toggles every cycle
      clr_stats();
      host_q.push_back(9'h0C3); host_q.push_back(9'h05A); host_q.push_back(9'h1F0);
      push_flags(4); push_cmd(2'd1, 8'hC3); push_cmd(2'd1, 8'h5A); push_cmd(2'd1, 8'hF0);
      push_cmd(2'd2, 8'h00); push_flags(2);
      bp_mode = 1'b1; tx_req = 1'b1;
      wait_ptt(1'b1, 400, "bp_keyup");
      tx_req = 1'b0;
      wait_sb(0, 600, "bp_frame");
      bp_mode = 1'b0; fr_ready = 1'b1; fr_empty = 1'b1;
      wait_ptt(1'b0, 50, "bp_unkey");
      fr_empty = 1'b0;
      chk("bp_tx_done", n_done, 1);
      cycle();

      // Asynchronous reset while in DATA
      clr_stats();
      host_q.push_back(9'h0AA); host_q.push_back(9'h0BB); host_q.push_back(9'h1CC);
      push_flags(4); push_cmd(2'd1, 8'hAA); push_cmd(2'd1, 8'hBB);
      push_cmd(2'd1, 8'hCC); push_cmd(2'd2, 8'h00); push_flags(2);
      tx_req = 1'b1;
      wait_ptt(1'b1, 400, "rst_keyup");
      tx_req = 1'b0;
      wait_sb(5, 600, "rst_data");
      fr_ready = 1'b0;
      cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ptt", 32'(ptt), 0);
      chk("arst_rx_en", 32'(rx_en), 1);
      chk("arst_state", 32'(state), 0);
      chk("arst_valid", 32'(fr_cmd_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete(); host_q.delete();
      fr_ready = 1'b1;
      tx_req = 1'b1;
      cycle();
      chk("arst_restart_defer", 32'(state), 1);
      tx_req = 1'b0;
      cycle();
      chk("arst_back_idle", 32'(state), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire
